gshare_hist_ctrl: RTL and testbench
===================================

GSHARE_HIST_CTRL -- requirements
Module: gshare_hist_ctrl

Interface
REQ-001 SHALL have parameter GHR_W, default 5, meaning global history width and PHT index width (PHT has 2^GHR_W entries).
REQ-002 SHALL have parameter CKPT_DEPTH, default 4, meaning the maximum number of in-flight predicted branches.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pred_valid  input  1  fetch requests a prediction for a branch at pred_pc.
REQ-006 pred_pc  input  32  PC of the branch being predicted.
REQ-007 pred_ready  output  1  high when a prediction request can be accepted this cycle.
REQ-008 pred_taken  output  1  predicted direction, combinational from current state.
REQ-009 res_valid  input  1  EX resolves the oldest in-flight branch.
REQ-010 res_taken  input  1  actual branch outcome.
REQ-011 res_mispredict  input  1  resolved outcome differs from the prediction; qualified by res_valid.
REQ-012 spec_ghr  output  GHR_W  speculative global history.
REQ-013 arch_ghr  output  GHR_W  committed global history.
REQ-014 inflight_cnt  output  clog2(CKPT_DEPTH+1)  number of occupied checkpoints.
REQ-015 err_underflow  output  1  sticky flag: resolve received with no in-flight branch.

Function
REQ-016 pht_idx SHALL equal pred_pc[GHR_W+1:2] XOR spec_ghr.
REQ-017 pred_taken SHALL equal bit 1 of PHT[pht_idx]; counter encoding is 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-018 pred_ready SHALL be !full AND !(res_valid AND res_mispredict); a pop in the same cycle does not free a full FIFO.
REQ-019 On accept (pred_valid AND pred_ready), SHALL push checkpoint {spec_ghr, pht_idx, pred_taken} and set spec_ghr <= {spec_ghr[GHR_W-2:0], pred_taken} at the next edge.
REQ-020 On res_valid with a non-empty FIFO, SHALL pop the head, set arch_ghr <= {arch_ghr[GHR_W-2:0], res_taken}, and saturating-update PHT[head.idx] toward res_taken (no wrap past 00 or 11).
REQ-021 On res_valid AND res_mispredict, SHALL set spec_ghr <= {head.ghr[GHR_W-2:0], res_taken}, empty the FIFO, and set inflight_cnt to 0, discarding all younger checkpoints.
REQ-022 Simultaneous accept and non-mispredict resolve SHALL push and pop in the same cycle, leaving inflight_cnt unchanged; spec_ghr follows REQ-019.
REQ-023 A prediction in the same cycle as a PHT write to the same index SHALL read the pre-update counter.
REQ-024 res_valid with an empty FIFO SHALL leave all state unchanged except setting err_underflow to 1.
REQ-025 FIFO pointers SHALL wrap modulo CKPT_DEPTH; full is inflight_cnt == CKPT_DEPTH.
REQ-026 Latency: a prediction is combinational in the request cycle; history and PHT changes are visible one cycle later.

Reset
REQ-027 On reset, SHALL set spec_ghr=0, arch_ghr=0, FIFO empty, inflight_cnt=0, err_underflow=0, and every PHT entry to 01.
REQ-028 Reset SHALL override all simultaneous pred and res activity; in-flight checkpoints are discarded.
REQ-029 After reset deasserts, pred_ready SHALL be 1 and pred_taken SHALL be 0 for any PC.

Structure
REQ-030 A shared package SHALL hold GHR_W, CKPT_DEPTH, the 2-bit counter encoding constants, and the checkpoint entry struct {ghr, idx, pred}.
REQ-031 The checkpoint queue SHALL be a separate sub-module, ghr_ckpt_fifo, with push, pop, clear, full, empty, and count; the PHT and history registers stay in the top level.

Verification
REQ-032 Reset, then pred_pc=0x00000010 with pred_valid -> pred_taken=0, pht_idx=0x04, and spec_ghr=00000 next cycle.
REQ-033 Resolve taken 3 times at pc 0x10 with arch_ghr held at 0 (flush between each) -> PHT[4] goes 01->10->11->11 (saturates), then pred_taken=1.
REQ-034 Accept 4 predictions without resolving -> pred_ready=0 and inflight_cnt=4; a 5th request is not accepted and spec_ghr is unchanged.
REQ-035 Spec path 00000 -> accept NT, T, T (spec_ghr=00011), then resolve oldest as mispredict with res_taken=1 -> spec_ghr=00001, arch_ghr=00001, inflight_cnt=0.
REQ-036 With the FIFO full, assert pred_valid and a correct res_valid in the same cycle -> pop occurs, push is refused, inflight_cnt=3; the next cycle's request is accepted.
REQ-037 res_valid on an empty FIFO -> err_underflow=1 and stays 1 until reset; arch_ghr and the PHT are unchanged.

Source files
------------

// File: rtl/gshare_hist_ctrl_pkg.sv
// Shared types and constants for the gshare history controller.
// Holds default sizes, 2-bit counter encodings and the checkpoint entry.
package gshare_hist_ctrl_pkg;

    localparam int GHR_W      = 5;
    localparam int CKPT_DEPTH = 4;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    typedef struct packed {
        logic [GHR_W-1:0] ghr;
        logic [GHR_W-1:0] idx;
        logic             pred;
    } ckpt_t;

    // Move a 2-bit counter one step toward the outcome, saturating at the ends.
    function automatic logic [1:0] ctr_update(input logic [1:0] c,
                                              input logic       taken);
        logic [1:0] n;
        n = c;
        if (taken && c != CTR_ST)
            n = c + 2'd1;
        else if (!taken && c != CTR_SNT)
            n = c - 2'd1;
        return n;
    endfunction

endpackage

// File: rtl/ghr_ckpt_fifo.sv
// Checkpoint queue for in-flight predicted branches.
// Head is the oldest entry; clear drops every entry at once.
module ghr_ckpt_fifo
    import gshare_hist_ctrl_pkg::*;
#(
    parameter int DEPTH = CKPT_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_i,
    input  ckpt_t                        data_i,
    input  logic                         pop_i,
    input  logic                         clear_i,
    output ckpt_t                        head_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST     = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    ckpt_t            mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Next pointers and occupancy; clear wins over push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push)
                wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
            if (do_pop)
                rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage; contents are only meaningful while counted.
    always_ff @(posedge clk) begin
        if (!reset && do_push && !clear_i)
            mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/gshare_hist_ctrl.sv
// Gshare direction predictor with speculative/committed global history.
// Checkpoints per in-flight branch allow history repair on a mispredict.
module gshare_hist_ctrl #(
    parameter int GHR_W      = gshare_hist_ctrl_pkg::GHR_W,
    parameter int CKPT_DEPTH = gshare_hist_ctrl_pkg::CKPT_DEPTH
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              pred_valid,
    input  logic [31:0]                       pred_pc,
    output logic                              pred_ready,
    output logic                              pred_taken,
    input  logic                              res_valid,
    input  logic                              res_taken,
    input  logic                              res_mispredict,
    output logic [GHR_W-1:0]                  spec_ghr,
    output logic [GHR_W-1:0]                  arch_ghr,
    output logic [$clog2(CKPT_DEPTH+1)-1:0]   inflight_cnt,
    output logic                              err_underflow
);

    import gshare_hist_ctrl_pkg::*;

    localparam int PHT_N = 2 ** GHR_W;

    logic [1:0]       pht_q [PHT_N];
    logic [GHR_W-1:0] spec_ghr_q, spec_ghr_d;
    logic [GHR_W-1:0] arch_ghr_q, arch_ghr_d;
    logic             err_q;

    logic [GHR_W-1:0] pht_idx;
    logic             accept;
    logic             res_fire;
    logic             flush;
    logic             fifo_full, fifo_empty;
    ckpt_t            head, push_ent;
    logic             unused_pc;

    assign unused_pc = ^{pred_pc[31:GHR_W+2], pred_pc[1:0]};

    assign pht_idx    = pred_pc[GHR_W+1:2] ^ spec_ghr_q;
    assign pred_taken = pht_q[pht_idx][1];
    assign pred_ready = !fifo_full && !(res_valid && res_mispredict);
    assign accept     = pred_valid && pred_ready;
    assign res_fire   = res_valid && !fifo_empty;
    assign flush      = res_fire && res_mispredict;

    assign push_ent = '{ghr: spec_ghr_q, idx: pht_idx, pred: pred_taken};

    assign spec_ghr      = spec_ghr_q;
    assign arch_ghr      = arch_ghr_q;
    assign err_underflow = err_q;

    ghr_ckpt_fifo #(
        .DEPTH (CKPT_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (accept),
        .data_i  (push_ent),
        .pop_i   (res_fire && !res_mispredict),
        .clear_i (flush),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (inflight_cnt)
    );

    // History next-state: repair from the head checkpoint beats speculation.
    always_comb begin
        spec_ghr_d = spec_ghr_q;
        arch_ghr_d = arch_ghr_q;
        if (flush)
            spec_ghr_d = {head.ghr[GHR_W-2:0], res_taken};
        else if (accept)
            spec_ghr_d = {spec_ghr_q[GHR_W-2:0], pred_taken};
        if (res_fire)
            arch_ghr_d = {arch_ghr_q[GHR_W-2:0], res_taken};
    end

    // History registers and sticky underflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            spec_ghr_q <= '0;
            arch_ghr_q <= '0;
            err_q      <= 1'b0;
        end else begin
            spec_ghr_q <= spec_ghr_d;
            arch_ghr_q <= arch_ghr_d;
            if (res_valid && fifo_empty)
                err_q <= 1'b1;
        end
    end

    // Pattern table: train the resolved branch's counter toward its outcome.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PHT_N; i++)
                pht_q[i] <= CTR_WNT;
        end else if (res_fire) begin
            pht_q[head.idx] <= ctr_update(pht_q[head.idx], res_taken);
        end
    end

endmodule

// File: tb/tb_gshare_hist_ctrl.sv
// Self-checking bench for gshare_hist_ctrl.
// A behavioural model feeds a scoreboard of expected outputs per cycle.
module tb_gshare_hist_ctrl;

    localparam int GW = 5;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          pred_valid;
    logic [31:0]   pred_pc;
    logic          pred_ready;
    logic          pred_taken;
    logic          res_valid;
    logic          res_taken;
    logic          res_mispredict;
    logic [GW-1:0] spec_ghr;
    logic [GW-1:0] arch_ghr;
    logic [2:0]    inflight_cnt;
    logic          err_underflow;

    gshare_hist_ctrl #(
        .GHR_W      (GW),
        .CKPT_DEPTH (D)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pred_valid     (pred_valid),
        .pred_pc        (pred_pc),
        .pred_ready     (pred_ready),
        .pred_taken     (pred_taken),
        .res_valid      (res_valid),
        .res_taken      (res_taken),
        .res_mispredict (res_mispredict),
        .spec_ghr       (spec_ghr),
        .arch_ghr       (arch_ghr),
        .inflight_cnt   (inflight_cnt),
        .err_underflow  (err_underflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [GW-1:0] ghr;
        logic [GW-1:0] idx;
        logic          pred;
    } ck_t;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    logic [1:0]    m_pht [32];
    ck_t           m_q [$];
    logic [GW-1:0] m_spec;
    logic [GW-1:0] m_arch;
    logic          m_err;
    sb_t           sb [$];
    int            n_chk = 0;
    int            n_err = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observe(input string tag);
        if (tag == "ready") return 32'(pred_ready);
        if (tag == "taken") return 32'(pred_taken);
        if (tag == "spec")  return 32'(spec_ghr);
        if (tag == "arch")  return 32'(arch_ghr);
        if (tag == "cnt")   return 32'(inflight_cnt);
        if (tag == "err")   return 32'(err_underflow);
        return 32'hdead_beef;
    endfunction

    task automatic drain();
        sb_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observe(e.tag), e.exp);
        end
    endtask

    task automatic push_state();
        sb.push_back('{tag: "spec", exp: 32'(m_spec)});
        sb.push_back('{tag: "arch", exp: 32'(m_arch)});
        sb.push_back('{tag: "cnt",  exp: 32'(m_q.size())});
        sb.push_back('{tag: "err",  exp: 32'(m_err)});
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_pht[i] = 2'b01;
        m_q.delete();
        m_spec = '0;
        m_arch = '0;
        m_err  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset          = 1'b1;
        pred_valid     = 1'b1;
        pred_pc        = 32'h0000_0010;
        res_valid      = 1'b1;
        res_taken      = 1'b1;
        res_mispredict = 1'($urandom);
        model_reset();
        push_state();
        @(posedge clk);
        #1 drain();
        @(negedge clk);
        reset      = 1'b0;
        pred_valid = 1'b0;
        res_valid  = 1'b0;
    endtask

    task automatic step(input logic pv, input logic [31:0] pc,
                        input logic rv, input logic rt, input logic rm);
        logic [GW-1:0] idx;
        logic          pt, rdy, acc;
        ck_t           h;
        @(negedge clk);
        pred_valid     = pv;
        pred_pc        = pc;
        res_valid      = rv;
        res_taken      = rt;
        res_mispredict = rm;
        idx = pc[GW+1:2] ^ m_spec;
        pt  = m_pht[idx][1];
        rdy = (m_q.size() < D) && !(rv && rm);
        acc = pv && rdy;
        sb.push_back('{tag: "ready", exp: 32'(rdy)});
        sb.push_back('{tag: "taken", exp: 32'(pt)});
        #1 drain();
        if (rv && m_q.size() == 0) begin
            m_err = 1'b1;
        end else if (rv) begin
            h = m_q[0];
            m_arch = {m_arch[GW-2:0], rt};
            if (rt && m_pht[h.idx] != 2'b11)
                m_pht[h.idx] = m_pht[h.idx] + 2'd1;
            else if (!rt && m_pht[h.idx] != 2'b00)
                m_pht[h.idx] = m_pht[h.idx] - 2'd1;
            if (rm) begin
                m_spec = {h.ghr[GW-2:0], rt};
                m_q.delete();
            end else begin
                void'(m_q.pop_front());
            end
        end
        if (acc) begin
            m_q.push_back('{ghr: m_spec, idx: idx, pred: pt});
            m_spec = {m_spec[GW-2:0], pt};
        end
        push_state();
        @(posedge clk);
        #1 drain();
    endtask

    // Resolve with a mispredict flag derived from the model's head entry.
    task automatic rstep(input logic pv, input logic [31:0] pc,
                         input logic rv, input logic rt);
        logic rm;
        rm = (m_q.size() > 0) ? (rt != m_q[0].pred) : 1'b0;
        step(pv, pc, rv, rt, rm);
    endtask

    function automatic logic [31:0] pc_for(input logic [GW-1:0] idx);
        return 32'(idx ^ m_spec) << 2;
    endfunction

    initial begin
        reset          = 1'b1;
        pred_valid     = 1'b0;
        pred_pc        = '0;
        res_valid      = 1'b0;
        res_taken      = 1'b0;
        res_mispredict = 1'b0;

        do_reset();
        step(0, 32'h0000_0000, 0, 0, 0);
        step(0, 32'hffff_fffc, 0, 0, 0);

        // First prediction at 0x10 lands on index 4, not taken.
        step(1, 32'h0000_0010, 0, 0, 0);
        check("idx4_first", 32'(m_q[0].idx), 32'h4);
        // Train index 4 toward taken until it saturates.
        step(0, 0, 1, 1, 1);
        rstep(1, pc_for(5'd4), 0, 0);
        rstep(0, 0, 1, 1);
        rstep(1, pc_for(5'd4), 0, 0);
        rstep(0, 0, 1, 1);
        check("pht4_sat", 32'(m_pht[4]), 32'h3);
        step(0, pc_for(5'd4), 0, 0, 0);

        // Fill the queue, then a fifth request must be refused.
        do_reset();
        for (int i = 0; i < D; i++) step(1, 32'(i) << 2, 0, 0, 0);
        step(1, 32'h0000_0040, 0, 0, 0);
        // Full plus a correct resolve: pop only, next request accepted.
        rstep(1, 32'h0000_0044, 1, m_q[0].pred);
        step(1, 32'h0000_0048, 0, 0, 0);
        while (m_q.size() > 0) rstep(0, 0, 1, 1'($urandom));

        // Three predictions then a mispredict on the oldest repairs history.
        do_reset();
        step(1, 32'h0000_0010, 0, 0, 0);
        step(1, 32'h0000_0020, 0, 0, 0);
        step(1, 32'h0000_0030, 0, 0, 0);
        step(0, 0, 1, 1, 1);

        // Resolve on an empty queue sets the sticky error.
        step(0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0);
        step(1, 32'h0000_0010, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);

        do_reset();
        repeat (400) begin
            rstep(($urandom % 4) != 0, $urandom,
                  ($urandom % 5) < 2, 1'($urandom));
        end
        do_reset();
        step(0, 32'h0000_0010, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
